// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the streaming FFT datapath.
package fft_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  // Widest component width the butterfly helper can carry.
  localparam int MAX_WIDTH = 32;

  typedef struct packed {
    logic signed [DEFAULT_DATA_WIDTH-1:0] re;
    logic signed [DEFAULT_DATA_WIDTH-1:0] im;
  } cplx_t;

  // (a +/- b) >>> 1 with one guard bit, so the halved result always fits the input range.
  function automatic logic signed [MAX_WIDTH-1:0] half_addsub(
    input logic signed [MAX_WIDTH-1:0] a,
    input logic signed [MAX_WIDTH-1:0] b,
    input logic                        sub
  );
    logic signed [MAX_WIDTH:0] wide;
    wide = sub ? ((MAX_WIDTH+1)'(a) - (MAX_WIDTH+1)'(b))
               : ((MAX_WIDTH+1)'(a) + (MAX_WIDTH+1)'(b));
    return MAX_WIDTH'(wide >>> 1);
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Feedback delay line of an SDF stage: a DELAY-deep register shift chain of complex samples.
module sdf_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DELAY      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] wr_real,
  input  logic [DATA_WIDTH-1:0] wr_imag,
  output logic [DATA_WIDTH-1:0] rd_real,
  output logic [DATA_WIDTH-1:0] rd_imag
);

  logic [DATA_WIDTH-1:0] re_q [DELAY];
  logic [DATA_WIDTH-1:0] im_q [DELAY];

  // NOTE: every entry is reset because the head is emitted as a difference after
  // a reset; the primed flag suppresses it, but zeroed storage keeps outputs deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (shift_en) begin
      // NOTE: non-blocking assignments make every stage read its neighbour's old value.
      re_q[0] <= wr_real;
      im_q[0] <= wr_imag;
      for (int i = 1; i < DELAY; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
      end
    end
  end

  assign rd_real = re_q[DELAY-1];
  assign rd_imag = im_q[DELAY-1];

endmodule

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: sums leave immediately,
// halved differences recirculate through the delay line and leave one half-frame later.
module r2sdf_stage
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DELAY      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag
);

  localparam int   CNT_W   = $clog2(2 * DELAY);
  localparam logic PH_FILL = 1'b0;
  localparam logic PH_BFLY = 1'b1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  primed_q, primed_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_re_q, out_re_d;
  logic [DATA_WIDTH-1:0] out_im_q, out_im_d;

  logic                  phase;
  logic [DATA_WIDTH-1:0] head_re, head_im;
  logic [DATA_WIDTH-1:0] wr_re, wr_im;
  logic signed [MAX_WIDTH-1:0] x_re_w, x_im_w, d_re_w, d_im_w;

  // 2*DELAY is a power of two, so the counter MSB is exactly cnt >= DELAY.
  assign phase = cnt_q[CNT_W-1];

  sdf_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .DELAY      (DELAY)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .shift_en (in_valid),
    .wr_real  (wr_re),
    .wr_imag  (wr_im),
    .rd_real  (head_re),
    .rd_imag  (head_im)
  );

  assign x_re_w = MAX_WIDTH'($signed(in_real));
  assign x_im_w = MAX_WIDTH'($signed(in_imag));
  assign d_re_w = MAX_WIDTH'($signed(head_re));
  assign d_im_w = MAX_WIDTH'($signed(head_im));

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    wr_re       = in_real;
    wr_im       = in_imag;
    if (in_valid) begin
      cnt_d       = cnt_q + CNT_W'(1);
      out_valid_d = (phase == PH_BFLY) || primed_q;
      if (phase == PH_BFLY) begin
        primed_d = 1'b1;
        out_re_d = DATA_WIDTH'(half_addsub(d_re_w, x_re_w, 1'b0));
        out_im_d = DATA_WIDTH'(half_addsub(d_im_w, x_im_w, 1'b0));
        wr_re    = DATA_WIDTH'(half_addsub(d_re_w, x_re_w, 1'b1));
        wr_im    = DATA_WIDTH'(half_addsub(d_im_w, x_im_w, 1'b1));
      end else begin
        out_re_d = head_re;
        out_im_d = head_im;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_re_q;
  assign out_imag  = out_im_q;

endmodule

// File: tb/tb_r2sdf_stage.sv
// Scoreboard bench for r2sdf_stage at DELAY = 2, 1 and 4 against a queue-based butterfly model.
module tb_r2sdf_stage;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int NI = 3;

  typedef struct {
    cplx_t v;
    int    cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iv  [NI];
  logic [DW-1:0] ire [NI];
  logic [DW-1:0] iim [NI];
  logic          ov  [NI];
  logic [DW-1:0] ore [NI];
  logic [DW-1:0] oim [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int    kidx   [NI];
  bit    primed [NI];
  cplx_t fh     [NI][$];
  cplx_t diffs  [NI][$];
  exp_t  sb     [NI][$];
  cplx_t cap    [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    r2sdf_stage #(
      .DATA_WIDTH (DW),
      .DELAY      ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_real   (ire[g]),
      .in_imag   (iim[g]),
      .out_valid (ov[g]),
      .out_real  (ore[g]),
      .out_imag  (oim[g])
    );
  end

  function automatic int dly(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Floor-halved sum or difference, in plain integer arithmetic.
  function automatic cplx_t half_ref(cplx_t a, cplx_t b, bit sub);
    cplx_t r;
    int    vr, vi;
    vr = sub ? (int'(a.re) - int'(b.re)) : (int'(a.re) + int'(b.re));
    vi = sub ? (int'(a.im) - int'(b.im)) : (int'(a.im) + int'(b.im));
    vr = vr >>> 1;
    vi = vi >>> 1;
    r.re = vr[DW-1:0];
    r.im = vi[DW-1:0];
    return r;
  endfunction

  // First-half samples wait in fh; halved differences wait in diffs for the next frame.
  task automatic model_step(int g, cplx_t x);
    exp_t  e;
    cplx_t a;
    e.cyc = cyc + 1;
    if (kidx[g] < dly(g)) begin
      if (primed[g]) begin
        e.v = diffs[g].pop_front();
        sb[g].push_back(e);
      end
      fh[g].push_back(x);
    end else begin
      a = fh[g].pop_front();
      primed[g] = 1'b1;
      e.v = half_ref(a, x, 1'b0);
      sb[g].push_back(e);
      diffs[g].push_back(half_ref(a, x, 1'b1));
    end
    kidx[g] = (kidx[g] + 1) % (2 * dly(g));
  endtask

  task automatic clear_model();
    for (int g = 0; g < NI; g++) begin
      kidx[g]   = 0;
      primed[g] = 1'b0;
      fh[g].delete();
      diffs[g].delete();
      sb[g].delete();
      cap[g].delete();
    end
  endtask

  task automatic drive(int g, int re, int im, bit v);
    cplx_t x;
    @(negedge clk);
    for (int i = 0; i < NI; i++) iv[i] = 1'b0;
    x.re   = re[DW-1:0];
    x.im   = im[DW-1:0];
    ire[g] = x.re;
    iim[g] = x.im;
    iv[g]  = v;
    if (v) model_step(g, x);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) iv[i] = 1'b0;
    end
  endtask

  task automatic check_zero(string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s_valid[%0d]", tag, g), int'(ov[g]), 0);
      check($sformatf("%s_real[%0d]", tag, g), int'($signed(ore[g])), 0);
      check($sformatf("%s_imag[%0d]", tag, g), int'($signed(oim[g])), 0);
    end
  endtask

  // Asserts rst between clock edges; optionally toggles inputs while held.
  task automatic do_reset(int n, bit toggle);
    @(negedge clk);
    for (int i = 0; i < NI; i++) iv[i] = 1'b0;
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    check_zero("rst_now");
    repeat (n) begin
      @(negedge clk);
      if (toggle) begin
        for (int i = 0; i < NI; i++) begin
          iv[i]  = 1'(i + cyc);
          ire[i] = DW'($urandom);
          iim[i] = DW'($urandom);
        end
      end
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) iv[i] = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  task automatic expect_cap(int g, string name, int re, int im);
    cplx_t c;
    check({name, "_present"}, int'(cap[g].size() > 0), 1);
    if (cap[g].size() > 0) begin
      c = cap[g].pop_front();
      check({name, "_re"}, int'(c.re), re);
      check({name, "_im"}, int'(c.im), im);
    end
  endtask

  // Monitor: pops the expected sample whose due cycle has come and compares valid and data.
  always @(negedge clk) begin
    bit    exp_v;
    exp_t  e;
    cplx_t c;
    if (!rst) begin
      for (int g = 0; g < NI; g++) begin
        exp_v = (sb[g].size() > 0) && (sb[g][0].cyc == cyc);
        check($sformatf("out_valid[%0d]@%0d", g, cyc), int'(ov[g]), int'(exp_v));
        if (ov[g]) begin
          c.re = ore[g];
          c.im = oim[g];
          cap[g].push_back(c);
        end
        if (exp_v) begin
          e = sb[g].pop_front();
          if (ov[g]) begin
            check($sformatf("out_real[%0d]@%0d", g, cyc), int'($signed(ore[g])), int'(e.v.re));
            check($sformatf("out_imag[%0d]@%0d", g, cyc), int'($signed(oim[g])), int'(e.v.im));
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      iv[i]  = 1'b0;
      ire[i] = '0;
      iim[i] = '0;
    end
    clear_model();

    do_reset(5, 1'b1);

    // DELAY=2 directed frame.
    drive(0, 1, 0, 1'b1);
    drive(0, 2, 0, 1'b1);
    drive(0, 3, 0, 1'b1);
    drive(0, 4, 0, 1'b1);
    drive(0, 0, 0, 1'b1);
    drive(0, 0, 0, 1'b1);
    idle(2);
    expect_cap(0, "d2_o0", 2, 0);
    expect_cap(0, "d2_o1", 3, 0);
    expect_cap(0, "d2_o2", -1, 0);
    expect_cap(0, "d2_o3", -1, 0);
    check("d2_extra", cap[0].size(), 0);

    // DELAY=1 extremes.
    do_reset(2, 1'b0);
    drive(1, 32767, 32767, 1'b1);
    drive(1, 32767, -32768, 1'b1);
    drive(1, 0, 0, 1'b1);
    idle(2);
    expect_cap(1, "ext_sum", 32767, -1);
    expect_cap(1, "ext_diff", 0, 32767);
    check("ext_extra", cap[1].size(), 0);
    do_reset(2, 1'b0);
    drive(1, -32768, 0, 1'b1);
    drive(1, 32767, 0, 1'b1);
    idle(2);
    expect_cap(1, "ext_neg", -1, 0);
    check("ext_neg_extra", cap[1].size(), 0);

    // DELAY=2 with a stall cycle carrying garbage data after every sample.
    do_reset(2, 1'b0);
    begin
      int seq [6] = '{1, 2, 3, 4, 0, 0};
      for (int i = 0; i < 6; i++) begin
        drive(0, seq[i], 0, 1'b1);
        drive(0, int'($urandom), int'($urandom), 1'b0);
      end
    end
    idle(2);
    expect_cap(0, "stall_o0", 2, 0);
    expect_cap(0, "stall_o1", 3, 0);
    expect_cap(0, "stall_o2", -1, 0);
    expect_cap(0, "stall_o3", -1, 0);
    check("stall_extra", cap[0].size(), 0);

    // DELAY=4: four continuous random frames, then a stretch with random stalls.
    do_reset(2, 1'b0);
    for (int i = 0; i < 32; i++) drive(2, int'($urandom), int'($urandom), 1'b1);
    for (int i = 0; i < 24; i++)
      drive(2, int'($urandom), int'($urandom), 1'($urandom_range(0, 1)));
    idle(2);

    // Reset three samples into a frame, then a fresh frame plus the next FILL half.
    do_reset(2, 1'b0);
    for (int i = 0; i < 11; i++) drive(2, int'($urandom), int'($urandom), 1'b1);
    do_reset(2, 1'b0);
    for (int i = 0; i < 8; i++) drive(2, int'($urandom), int'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) drive(2, 0, 0, 1'b1);
    idle(3);

    for (int g = 0; g < NI; g++)
      check($sformatf("sb_drained[%0d]", g), sb[g].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
